// File: rtl/systolic_pkg.sv
// Shared constants for the systolic array edge logic: default array size,
// lane-slice width and the flush counter width helper.
package systolic_pkg;

    localparam int SKEW_N          = 4;
    localparam int SKEW_DATA_WIDTH = 16;
    localparam int SKEW_LANE_W     = SKEW_DATA_WIDTH;

    // Counter must hold the value N itself, hence N+1 codes.
    function automatic int flush_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int SKEW_FLUSH_W = flush_cnt_width(SKEW_N);

endpackage

// File: rtl/skew_delay_line.sv
// Enabled shift register of STAGES words; output is the last stage.
// Used once per lane to build the diagonal skew in front of the array.
module skew_delay_line #(
    parameter int STAGES     = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] stage_q [STAGES];
    logic [DATA_WIDTH-1:0] stage_d [STAGES];

    // NOTE: next-state starts as a copy of the current state so every path assigns it and no latch is inferred.
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = d;
            for (int s = 1; s < STAGES; s++) begin
                stage_d[s] = stage_q[s - 1];
            end
        end
    end

    // NOTE: state registers use <= so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES - 1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand edge feeder: input FIFO, per-lane diagonal skew and PE pause line.
// Define SKEW_FLUSH_EN to honour in_last with a zero flush and tile_done pulse.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N          = SKEW_N,
    parameter int DATA_WIDTH = SKEW_LANE_W,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*DATA_WIDTH-1:0]    in_data,
    input  logic                       in_last,
    output logic [N*DATA_WIDTH-1:0]    out_data,
    output logic                       out_pause,
    output logic                       tile_done,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int VEC_W = N * DATA_WIDTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SKEW_FLUSH_EN
    localparam int ENTRY_W = VEC_W + 1;
    localparam int FC_W    = flush_cnt_width(N);
`else
    localparam int ENTRY_W = VEC_W;
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push;
    logic               pop;
    logic               adv;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] wr_entry;
    logic [VEC_W-1:0]   skew_in;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign out_pause  = !adv;

`ifdef SKEW_FLUSH_EN
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic            head_last;

    assign wr_entry  = {in_last, in_data};
    assign head_last = head[ENTRY_W-1];
    assign adv       = (flush_cnt_q != '0) || (count_q != '0);
    // A pending flush wins over the next tile, so pop only when no flush is left.
    assign pop       = adv && (flush_cnt_q == '0);
    assign tile_done = adv && (flush_cnt_q == FC_W'(1));
    assign skew_in   = pop ? head[VEC_W-1:0] : '0;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (adv) begin
            if (flush_cnt_q != '0) begin
                flush_cnt_d = flush_cnt_q - FC_W'(1);
            end else if (head_last) begin
                flush_cnt_d = FC_W'(N);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end
`else
    logic unused_in_last;

    assign unused_in_last = in_last;
    assign wr_entry       = in_data;
    // Without flushing, the tail of a tile only moves when later vectors arrive.
    assign adv            = (count_q != '0);
    assign pop            = adv;
    assign tile_done      = 1'b0;
    assign skew_in        = head;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: FIFO storage has no reset; count and pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .STAGES     (i + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_delay (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (adv),
            .d       (skew_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .q       (out_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=4, DATA_WIDTH=16, DEPTH=4).
// Flush-specific scenarios are selected with SKEW_FLUSH_EN, matching the RTL build.
module tb_systolic_skew_feeder;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int VW    = N * DW;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [VW-1:0] in_data  = '0;
    logic          in_ready;
    logic [VW-1:0] out_data;
    logic          out_pause;
    logic          tile_done;
    logic [2:0]    fifo_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .N          (N),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_pause  (out_pause),
        .tile_done  (tile_done),
        .fifo_count (fifo_count)
    );

    function automatic logic [VW-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // Streaming vector k, lane i.
    function automatic int sval(input int k, input int i);
        return (k + 1) * 16 + i + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 1'b1;
        in_data  = pack4(4, 3, 2, 1);
        tick();
        in_data  = pack4(8, 7, 6, 5);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_data !== pack4(0, 0, 0, 1)) begin
            miscompares++;
            $display("FAIL reset_pre out_data got %h want %h", out_data, pack4(0, 0, 0, 1));
        end
        vectors++;
        if (fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_pre fifo_count got %0d want 1", fifo_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_data !== '0) begin
            miscompares++;
            $display("FAIL reset out_data got %h want 0", out_data);
        end
        vectors++;
        if (out_pause !== 1'b1) begin
            miscompares++;
            $display("FAIL reset out_pause got %b want 1", out_pause);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset in_ready got %b want 1", in_ready);
        end
        vectors++;
        if (fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset fifo_count got %0d want 0", fifo_count);
        end
        vectors++;
        if (tile_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset tile_done got %b want 0", tile_done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_tile();
        logic [VW-1:0] exp_out [1:5];
        logic          exp_td  [1:5];
        logic          exp_p   [1:5];
        do_reset();
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = pack4(4, 3, 2, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (out_pause !== 1'b0) begin
            miscompares++;
            $display("FAIL single_e0 out_pause got %b want 0", out_pause);
        end
`ifdef SKEW_FLUSH_EN
        exp_out[1] = pack4(0, 0, 0, 1); exp_td[1] = 1'b0; exp_p[1] = 1'b0;
        exp_out[2] = pack4(0, 0, 2, 0); exp_td[2] = 1'b0; exp_p[2] = 1'b0;
        exp_out[3] = pack4(0, 3, 0, 0); exp_td[3] = 1'b0; exp_p[3] = 1'b0;
        exp_out[4] = pack4(4, 0, 0, 0); exp_td[4] = 1'b1; exp_p[4] = 1'b0;
        exp_out[5] = pack4(0, 0, 0, 0); exp_td[5] = 1'b0; exp_p[5] = 1'b1;
`else
        exp_out[1] = pack4(0, 0, 0, 1); exp_td[1] = 1'b0; exp_p[1] = 1'b1;
        exp_out[2] = pack4(0, 0, 0, 1); exp_td[2] = 1'b0; exp_p[2] = 1'b1;
        exp_out[3] = pack4(0, 0, 0, 1); exp_td[3] = 1'b0; exp_p[3] = 1'b1;
        exp_out[4] = pack4(0, 0, 0, 1); exp_td[4] = 1'b0; exp_p[4] = 1'b0;
        exp_out[5] = pack4(0, 0, 2, 5); exp_td[5] = 1'b0; exp_p[5] = 1'b1;
`endif
        for (int m = 1; m <= 5; m++) begin
`ifndef SKEW_FLUSH_EN
            // Without flush, the tail only moves when the next vector arrives.
            in_valid = (m == 4);
            in_data  = pack4(8, 7, 6, 5);
`endif
            tick();
            in_valid = 1'b0;
            vectors++;
            if (out_data !== exp_out[m]) begin
                miscompares++;
                $display("FAIL single_e%0d out_data got %h want %h", m, out_data, exp_out[m]);
            end
            vectors++;
            if (tile_done !== exp_td[m]) begin
                miscompares++;
                $display("FAIL single_e%0d tile_done got %b want %b", m, tile_done, exp_td[m]);
            end
            vectors++;
            if (out_pause !== exp_p[m]) begin
                miscompares++;
                $display("FAIL single_e%0d out_pause got %b want %b", m, out_pause, exp_p[m]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] exp_v;
        do_reset();
        for (int m = 0; m <= 8; m++) begin
            if (m < 8) begin
                in_valid = 1'b1;
                in_data  = pack4(sval(m, 3), sval(m, 2), sval(m, 1), sval(m, 0));
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_e%0d in_ready got %b want 1", m, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            vectors++;
            if (out_pause !== (m == 8)) begin
                miscompares++;
                $display("FAIL stream_e%0d out_pause got %b want %b", m, out_pause, (m == 8));
            end
            if (m >= 1) begin
                exp_v = '0;
                for (int i = 0; i < N; i++) begin
                    if (m - 1 - i >= 0) exp_v[i*DW +: DW] = 16'(sval(m - 1 - i, i));
                end
                vectors++;
                if (out_data !== exp_v) begin
                    miscompares++;
                    $display("FAIL stream_e%0d out_data got %h want %h", m, out_data, exp_v);
                end
            end
        end
    endtask

    task automatic test_gap();
        logic [VW-1:0] hold_v;
        hold_v = pack4(0, 0, 0, 'hA0);
        do_reset();
        in_valid = 1'b1;
        in_data  = pack4('hA3, 'hA2, 'hA1, 'hA0);
        tick();
        in_valid = 1'b0;
        for (int m = 1; m <= 3; m++) begin
            tick();
            vectors++;
            if (out_pause !== 1'b1) begin
                miscompares++;
                $display("FAIL gap_e%0d out_pause got %b want 1", m, out_pause);
            end
            vectors++;
            if (out_data !== hold_v) begin
                miscompares++;
                $display("FAIL gap_e%0d out_data got %h want %h", m, out_data, hold_v);
            end
        end
        in_valid = 1'b1;
        in_data  = pack4('hB3, 'hB2, 'hB1, 'hB0);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_pause !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_e4 out_pause got %b want 0", out_pause);
        end
        vectors++;
        if (out_data !== hold_v) begin
            miscompares++;
            $display("FAIL gap_e4 out_data got %h want %h", out_data, hold_v);
        end
        tick();
        vectors++;
        if (out_data !== pack4(0, 0, 'hA1, 'hB0)) begin
            miscompares++;
            $display("FAIL gap_e5 out_data got %h want %h", out_data, pack4(0, 0, 'hA1, 'hB0));
        end
        vectors++;
        if (out_pause !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_e5 out_pause got %b want 1", out_pause);
        end
    endtask

`ifdef SKEW_FLUSH_EN
    task automatic test_full();
        logic [VW-1:0] bvec [5];
        int            exp_l0 [6];
        int            seen [$];
        int            qidx;
        int            max_cnt;
        int            low_cycles;
        int            done_pulses;
        logic          accepted;
        logic          pre_pause;
        for (int k = 0; k < 5; k++) begin
            bvec[k] = pack4('h51 + k, 'h41 + k, 'h31 + k, 'h21 + k);
        end
        exp_l0 = '{'h10, 'h21, 'h22, 'h23, 'h24, 'h25};
        qidx = 0; max_cnt = 0; low_cycles = 0; done_pulses = 0;
        do_reset();
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = pack4('h13, 'h12, 'h11, 'h10);
        tick();
        in_last = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            accepted = 1'b0;
            if (c >= 2 && qidx < 5) begin
                in_valid = 1'b1;
                in_data  = bvec[qidx];
                accepted = in_ready;
            end else begin
                in_valid = 1'b0;
            end
            pre_pause = out_pause;
            tick();
            if (accepted) qidx++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (!in_ready) low_cycles++;
            if (tile_done) done_pulses++;
            if (!pre_pause && out_data[DW-1:0] != '0) seen.push_back(int'(out_data[DW-1:0]));
        end
        in_valid = 1'b0;
        vectors++;
        if (max_cnt != DEPTH) begin
            miscompares++;
            $display("FAIL full max_fifo_count got %0d want %0d", max_cnt, DEPTH);
        end
        vectors++;
        if (low_cycles != 1) begin
            miscompares++;
            $display("FAIL full in_ready_low_cycles got %0d want 1", low_cycles);
        end
        vectors++;
        if (done_pulses != 1) begin
            miscompares++;
            $display("FAIL full tile_done_pulses got %0d want 1", done_pulses);
        end
        vectors++;
        if (qidx != 5) begin
            miscompares++;
            $display("FAIL full accepted got %0d want 5", qidx);
        end
        vectors++;
        if (seen.size() != 6) begin
            miscompares++;
            $display("FAIL full lane0_count got %0d want 6", seen.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                vectors++;
                if (seen[j] != exp_l0[j]) begin
                    miscompares++;
                    $display("FAIL full lane0_order[%0d] got %h want %h", j, seen[j], exp_l0[j]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_gap();
`ifdef SKEW_FLUSH_EN
        test_full();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge feeder for the systolic array operand inputs. Accepts one N-lane operand vector per cycle over a valid/ready handshake and buffers it in a small FIFO. Applies the diagonal skew so that lane i reaches the array edge i cycles after lane 0. Drives the shared pause line that freezes the PE input registers whenever no operand is available. At tile end, zeros are flushed through the skew so the last operands fully enter the array.

## Interface
- N, 4, array dimension and lane count (≥1)
- DATA_WIDTH, 16, operand width per lane
- DEPTH, 4, input FIFO depth in vectors (≥2)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer holds a vector
- in_ready  out  1  FIFO can accept; equals !full
- in_data  in  N*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  1  vector is the last of a tile; sampled with the handshake
- out_data  out  N*DATA_WIDTH  skewed operands to the array edge PE registers
- out_pause  out  1  to the PE pause inputs; high means hold
- tile_done  out  1  one-cycle pulse on the final flush advance
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Push: when in_valid && in_ready, store {in_last, in_data}. A push into an empty FIFO is not bypassed.
- Advance condition: adv = (flush_cnt != 0) || (fifo_count != 0). out_pause = !adv. It is derived only from registers and has no in_valid-to-out path.
- Advance with flush_cnt == 0: pop the head vector into the skew.
  - If the popped vector has last set, load flush_cnt = N.
- Advance with flush_cnt != 0: inject a zero vector into the skew, decrement flush_cnt, do not pop. A pending flush has priority over the next tile's data.
- Skew structure: lane i passes through i+1 enabled registers. All registers shift only on adv.
- tile_done = adv && flush_cnt == 1. For N=1 this is the single flush cycle.
- Push and pop in the same cycle are allowed: occupancy is unchanged.
- When full, in_ready = 0 and the push is refused. Data is never overwritten.

## Timing
- Reset (asynchronous assert, synchronous-clock deassert):
  - FIFO empty, flush_cnt = 0, all skew registers 0.
  - out_data = 0, out_pause = 1, in_ready = 1, fifo_count = 0, tile_done = 0.
- Reset asserted mid-tile discards all buffered and in-flight data. There is no partial flush.
- Latency: a vector pushed at edge E0 is popped at E1. Lane i is valid on out_data after edge E(1+i) and is consumed by the PE at E(2+i).
- Flush: N advances after popping a last vector, covering edges E2..E(N+1). The lane N-1 operand is therefore consumed before pause reasserts.
- Steady state: continuous pushes give out_pause = 0 on every cycle, with throughput of one vector per cycle.

## Configuration
- SKEW_FLUSH_EN defined: in_last is honoured and performs the zero flush and tile_done behaviour described above.
- SKEW_FLUSH_EN undefined:
  - in_last is ignored and not stored. flush_cnt logic is removed and tile_done is tied to 0.
  - adv = fifo_count != 0, so skewed tail data advances only when later vectors arrive.

## Structure
- Shared package systolic_pkg holds:
  - the default N and DATA_WIDTH constants;
  - the lane-slice width constant;
  - the flush counter width, $clog2(N+1).
- Sub-module skew_delay_line (parameters STAGES, DATA_WIDTH; ports clk, reset_n, en, d, q). It is instantiated N times in a generate loop with STAGES = i+1.
- The FIFO is inline: circular buffer, read/write pointers, and a count register.

## Test plan
- Reset: drive reset_n low while 2 vectors are in flight -> out_data = 0, out_pause = 1, in_ready = 1, fifo_count = 0, tile_done = 0, asynchronously.
- Single tile (N=4): push {4,3,2,1} (lane3..0) with in_last at E0:
  - lane0 = 1 after E1, lane1 = 2 after E2, lane2 = 3 after E3, lane3 = 4 after E4;
  - zeros follow, tile_done high in the cycle before E5, out_pause = 1 after E5.
- Streaming: push 8 vectors back-to-back with DEPTH=4 -> in_ready stays 1 and out_pause stays 0 throughout; lane i carries vector k after edge E(k+1+i).
- Full: issue a tile with last, then push 5 vectors during its 4-cycle flush -> fifo_count reaches 4 and in_ready = 0 for one cycle. No loss, order preserved.
- Gap: push v0, idle 3 cycles, push v1 -> out_pause = 1 for the gap, out_data holds, and the skew resumes with correct lane alignment.
- SKEW_FLUSH_EN undefined: push one vector with in_last -> tile_done never pulses and out_pause = 1 after one advance, with lanes 1..3 held in the skew.
